// File: rtl/axilite_regbus_bridge.sv
// AXI4-Lite slave that turns AXI read/write transactions into single-beat
// register-bus requests, with decode-error and timeout responses.
module axilite_regbus_bridge #(
    parameter int              DATA_WIDTH     = 32,
    parameter int              ADDR_WIDTH     = 32,
    parameter longint unsigned BASE_ADDR      = 0,
    parameter longint unsigned ADDR_SPAN      = 'h1000,
    parameter int              TIMEOUT_CYCLES = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    input  logic                    bus_ready,
    input  logic                    bus_err,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH+1:0] WIN_LO   = (ADDR_WIDTH + 2)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH+1:0] WIN_SPAN = (ADDR_WIDTH + 2)'(ADDR_SPAN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_W - 1));

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS_RD, ST_BUS_WR} state_t;

    state_t                state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  wr_issued_q, wr_issued_d;
    logic                  rd_issued_q, rd_issued_d;
    logic                  last_grant_wr_q, last_grant_wr_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    logic                  wr_elig, rd_elig, grant_wr, grant_rd, idle;
    logic                  cur_is_wr, addr_hit, bus_active;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH+1:0] addr_off;
    logic [DATA_WIDTH-1:0] biten_full;
    logic                  fin;
    logic [1:0]            fin_resp;
    logic [DATA_WIDTH-1:0] fin_data;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_biten
        assign biten_full[gi*8 +: 8] = {8{w_strb_q[gi]}};
    end

    assign wr_elig  = aw_full_q & w_full_q & ~wr_issued_q & ~bvalid_q;
    assign rd_elig  = ar_full_q & ~rd_issued_q & ~rvalid_q;
    assign grant_wr = wr_elig & (~rd_elig | ~last_grant_wr_q);
    assign grant_rd = rd_elig & ~grant_wr;
    assign idle     = (state_q == ST_IDLE);

    // The bus cycle starts combinationally in the grant cycle, so the
    // active request class comes from the grant in IDLE and from the state otherwise.
    assign cur_is_wr  = idle ? grant_wr : (state_q == ST_BUS_WR);
    assign cur_addr   = cur_is_wr ? aw_addr_q : ar_addr_q;
    assign addr_off   = {2'b00, cur_addr} - WIN_LO;
    assign addr_hit   = (addr_off < WIN_SPAN);
    assign bus_active = idle ? ((grant_wr | grant_rd) & addr_hit) : 1'b1;

    assign bus_req       = bus_active;
    assign bus_req_is_wr = bus_active & cur_is_wr;
    assign bus_addr      = bus_active ? (cur_addr & ALIGN_MASK) : '0;
    assign bus_wr_data   = (bus_active & cur_is_wr) ? w_data_q : '0;
    assign bus_wr_biten  = (bus_active & cur_is_wr) ? biten_full : '0;

    assign AWREADY = ~aw_full_q;
    assign WREADY  = ~w_full_q;
    assign ARREADY = ~ar_full_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    always_comb begin
        state_d         = state_q;
        aw_full_d       = aw_full_q;
        aw_addr_d       = aw_addr_q;
        w_full_d        = w_full_q;
        w_data_d        = w_data_q;
        w_strb_d        = w_strb_q;
        ar_full_d       = ar_full_q;
        ar_addr_d       = ar_addr_q;
        wr_issued_d     = wr_issued_q;
        rd_issued_d     = rd_issued_q;
        last_grant_wr_d = last_grant_wr_q;
        bvalid_d        = bvalid_q;
        bresp_d         = bresp_q;
        rvalid_d        = rvalid_q;
        rresp_d         = rresp_q;
        rdata_d         = rdata_q;
        wait_cnt_d      = wait_cnt_q;
        fin             = 1'b0;
        fin_resp        = RESP_OKAY;
        fin_data        = '0;

        if (AWVALID && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end
        if (WVALID && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end
        if (ARVALID && !ar_full_q) begin
            ar_full_d = 1'b1;
            ar_addr_d = ARADDR;
        end
        if (bvalid_q && BREADY) begin
            bvalid_d    = 1'b0;
            aw_full_d   = 1'b0;
            w_full_d    = 1'b0;
            wr_issued_d = 1'b0;
        end
        if (rvalid_q && RREADY) begin
            rvalid_d    = 1'b0;
            ar_full_d   = 1'b0;
            rd_issued_d = 1'b0;
        end

        if (idle && (grant_wr || grant_rd)) begin
            last_grant_wr_d = grant_wr;
            if (grant_wr) wr_issued_d = 1'b1;
            else          rd_issued_d = 1'b1;
            if (!addr_hit) begin
                fin      = 1'b1;
                fin_resp = RESP_DECERR;
            end
        end

        // The wait counter includes the grant cycle, so bus_req is high for
        // exactly TIMEOUT_CYCLES cycles when bus_ready never comes.
        if (bus_active) begin
            if (bus_ready) begin
                fin      = 1'b1;
                fin_resp = bus_err ? RESP_SLVERR : RESP_OKAY;
                fin_data = bus_err ? '0 : bus_rd_data;
            end else if (TO_EN && (wait_cnt_q == CNT_LAST)) begin
                fin      = 1'b1;
                fin_resp = RESP_SLVERR;
            end else begin
                state_d    = cur_is_wr ? ST_BUS_WR : ST_BUS_RD;
                wait_cnt_d = TO_EN ? (wait_cnt_q + CNT_W'(1)) : '0;
            end
        end

        if (fin) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            if (cur_is_wr) begin
                bvalid_d = 1'b1;
                bresp_d  = fin_resp;
            end else begin
                rvalid_d = 1'b1;
                rresp_d  = fin_resp;
                rdata_d  = fin_data;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q         <= ST_IDLE;
            aw_full_q       <= 1'b0;
            aw_addr_q       <= '0;
            w_full_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ar_full_q       <= 1'b0;
            ar_addr_q       <= '0;
            wr_issued_q     <= 1'b0;
            rd_issued_q     <= 1'b0;
            last_grant_wr_q <= 1'b0;
            bvalid_q        <= 1'b0;
            bresp_q         <= RESP_OKAY;
            rvalid_q        <= 1'b0;
            rresp_q         <= RESP_OKAY;
            rdata_q         <= '0;
            wait_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            aw_full_q       <= aw_full_d;
            aw_addr_q       <= aw_addr_d;
            w_full_q        <= w_full_d;
            w_data_q        <= w_data_d;
            w_strb_q        <= w_strb_d;
            ar_full_q       <= ar_full_d;
            ar_addr_q       <= ar_addr_d;
            wr_issued_q     <= wr_issued_d;
            rd_issued_q     <= rd_issued_d;
            last_grant_wr_q <= last_grant_wr_d;
            bvalid_q        <= bvalid_d;
            bresp_q         <= bresp_d;
            rvalid_q        <= rvalid_d;
            rresp_q         <= rresp_d;
            rdata_q         <= rdata_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_axilite_regbus_bridge.sv
// Self-checking bench for axilite_regbus_bridge: vector table, response
// scoreboard, behavioural register-map responder and cycle-exact sequences.
module tb_axilite_regbus_bridge;

    logic        ACLK;
    logic        ARESETN;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        bus_req, bus_req_is_wr, bus_ready, bus_err;
    logic [31:0] bus_addr, bus_wr_data, bus_wr_biten, bus_rd_data;

    axilite_regbus_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(0),
        .ADDR_SPAN('h100), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd_val;
        logic        err;
        int          delay;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_req;
        logic [31:0] exp_baddr;
        logic [31:0] exp_biten;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    rsp_t        exp_wr_q[$];
    rsp_t        exp_rd_q[$];
    logic        issue_log[$];
    logic        b_stall = 1'b0, r_stall = 1'b0, stray = 1'b0;
    int          rm_delay = 0;
    logic [31:0] rm_data = '0;
    logic        rm_err = 1'b0;
    int          req_run = 0, last_req_len = 0;
    logic        req_seen = 1'b0, first_wr = 1'b0;
    logic [31:0] first_addr = '0, first_data = '0, first_biten = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [1:0] resp);
        rsp_t e;
        e.resp = resp; e.rdata = '0;
        exp_wr_q.push_back(e);
    endtask

    task automatic push_rd(input logic [1:0] resp, input logic [31:0] data);
        rsp_t e;
        e.resp = resp; e.rdata = data;
        exp_rd_q.push_back(e);
    endtask

    // One clock: scoreboard pops, then the register-map responder for this cycle.
    task automatic tick();
        rsp_t e;
        @(negedge ACLK);
        BREADY = !b_stall;
        RREADY = !r_stall;
        if (BVALID && BREADY) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL b_unexpected: got BRESP %0h, required no response", BRESP);
            end else begin
                e = exp_wr_q.pop_front();
                chk("bresp", BRESP, e.resp);
            end
        end
        if (RVALID && RREADY) begin
            if (exp_rd_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL r_unexpected: got RRESP %0h, required no response", RRESP);
            end else begin
                e = exp_rd_q.pop_front();
                chk("rresp", RRESP, e.resp);
                chk("rdata", RDATA, e.rdata);
            end
        end
        bus_ready   = 1'b0;
        bus_err     = 1'b1;
        bus_rd_data = 32'hBAD0_BAD0;
        if (bus_req) begin
            req_run++;
            if (req_run == 1) begin
                req_seen    = 1'b1;
                first_wr    = bus_req_is_wr;
                first_addr  = bus_addr;
                first_data  = bus_wr_data;
                first_biten = bus_wr_biten;
                issue_log.push_back(bus_req_is_wr);
            end else begin
                chk("bus_hold", {bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten},
                    {first_wr, first_addr, first_data, first_biten});
            end
            if (rm_delay >= 0 && req_run - 1 == rm_delay) begin
                bus_ready    = 1'b1;
                bus_err      = rm_err;
                bus_rd_data  = rm_data;
                last_req_len = req_run;
                req_run      = 0;
            end
        end else begin
            if (req_run > 0) begin
                last_req_len = req_run;
                req_run      = 0;
            end
            bus_ready = stray;
        end
    endtask

    task automatic send(input logic do_aw, input logic do_w, input logic do_ar,
                        input logic [31:0] aw_a, input logic [31:0] w_d,
                        input logic [3:0] w_s, input logic [31:0] ar_a);
        int   guard;
        logic aw_hs, w_hs, ar_hs;
        guard   = 0;
        AWVALID = do_aw; AWADDR = aw_a;
        WVALID  = do_w;  WDATA  = w_d; WSTRB = w_s;
        ARVALID = do_ar; ARADDR = ar_a;
        while ((AWVALID || WVALID || ARVALID) && guard < 50) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            ar_hs = ARVALID && ARREADY;
            tick();
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
            if (ar_hs) ARVALID = 1'b0;
            guard++;
        end
        if (AWVALID || WVALID || ARVALID) begin
            n_checks++; n_errors++;
            $display("FAIL send_accept: got no address/data handshake in 50 cycles, required acceptance");
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got no response within %0d cycles, required a response", name, max_cyc);
            exp_wr_q.delete();
            exp_rd_q.delete();
        end
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        tick();
        tick();
        exp_wr_q.delete();
        exp_rd_q.delete();
        issue_log.delete();
        ARESETN = 1'b1;
        tick();
    endtask

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required the bench to finish");
        $fatal(1);
    end

    initial begin
        int n;
        ARESETN = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
        BREADY = 1'b1; RREADY = 1'b1;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;

        //           wr    addr          wdata         strb  rd_val        err  dly resp   rdata         req   baddr         biten
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h5, 32'h0,        1'b0, 0, 2'b00, 32'h0,        1'b1, 32'h10, 32'h00FF_00FF};
        vecs[1] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 2, 2'b00, 32'hA5A5_A5A5, 1'b1, 32'h10, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h1111_1111, 1'b0, 0, 2'b11, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'h7777_7777, 4'hF, 32'h0,        1'b0, 0, 2'b11, 32'h0,        1'b0, 32'h0,  32'h0};
        vecs[4] = '{1'b0, 32'h0000_00FF, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 1, 2'b00, 32'h1234_5678, 1'b1, 32'hFC, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hFFFF_0000, 1'b1, 0, 2'b10, 32'h0,        1'b1, 32'h20, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_0047, 32'h0102_0304, 4'hF, 32'h0,        1'b1, 3, 2'b10, 32'h0,        1'b1, 32'h44, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 32'h0000_0008, 32'h55AA_55AA, 4'hA, 32'h0,        1'b0, 1, 2'b00, 32'h0,        1'b1, 32'h08, 32'hFF00_FF00};
        vecs[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h2222_2222, 1'b0, 0, 2'b11, 32'h0,        1'b0, 32'h0,  32'h0};

        tick();
        tick();
        chk("rst_awready", AWREADY, 1'b1);
        chk("rst_wready", WREADY, 1'b1);
        chk("rst_arready", ARREADY, 1'b1);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_bresp_rresp", {BRESP, RRESP}, 4'h0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_bus_out", {bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten}, '0);
        ARESETN = 1'b1;
        tick();

        // AW at cycle 0, W at cycle 3: issue at 4, response at 5.
        rm_delay = 0; rm_err = 1'b0;
        push_wr(2'b00);
        AWVALID = 1'b1; AWADDR = 32'h10;
        chk("seq_awready", AWREADY, 1'b1);
        tick();
        AWVALID = 1'b0;
        chk("seq_no_req_c1", bus_req, 1'b0);
        tick();
        chk("seq_no_req_c2", bus_req, 1'b0);
        tick();
        chk("seq_no_req_c3", bus_req, 1'b0);
        WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'h5;
        tick();
        WVALID = 1'b0;
        chk("seq_req_c4", {bus_req, bus_req_is_wr}, 2'b11);
        chk("seq_addr_c4", bus_addr, 32'h10);
        chk("seq_wdata_c4", bus_wr_data, 32'hDEAD_BEEF);
        chk("seq_biten_c4", bus_wr_biten, 32'h00FF_00FF);
        tick();
        chk("seq_bvalid_c5", {BVALID, BRESP}, 3'b100);
        wait_idle(10, "seq_write");
        $display("txn seq_write addr=10 done");

        // Read with 2-cycle regmap latency and RREADY held low for 3 cycles.
        r_stall = 1'b1; rm_delay = 2; rm_data = 32'hA5A5_A5A5;
        push_rd(2'b00, 32'hA5A5_A5A5);
        send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h13);
        n = 0;
        while (!RVALID && n < 20) begin
            tick();
            n++;
        end
        chk("hold_rd_latency", n, 3);
        chk("hold_bus_addr", {first_wr, first_addr}, {1'b0, 32'h10});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rvalid", RVALID, 1'b1);
            chk("hold_rdata", {RRESP, RDATA}, {2'b00, 32'hA5A5_A5A5});
        end
        r_stall = 1'b0;
        wait_idle(10, "hold_read");
        $display("txn hold_read addr=13 done");

        // First contest after reset goes to the write, the next one to the read.
        do_reset();
        rm_delay = 1; rm_data = 32'hC0FF_EE11; rm_err = 1'b0;
        push_wr(2'b00);
        push_rd(2'b00, 32'hC0FF_EE11);
        send(1'b1, 1'b1, 1'b1, 32'h20, 32'h1357_9BDF, 4'hF, 32'h24);
        wait_idle(60, "contest1");
        chk("contest1_count", issue_log.size(), 2);
        chk("contest1_order", {issue_log[0], issue_log[1]}, 2'b10);
        $display("txn contest1 done");
        push_wr(2'b00);
        send(1'b1, 1'b1, 1'b0, 32'h28, 32'h0, 4'h1, 32'h0);
        wait_idle(60, "lone_write");
        issue_log.delete();
        rm_data = 32'h0BAD_F00D;
        push_wr(2'b00);
        push_rd(2'b00, 32'h0BAD_F00D);
        send(1'b1, 1'b1, 1'b1, 32'h30, 32'h2468_ACE0, 4'h3, 32'h34);
        wait_idle(60, "contest2");
        chk("contest2_count", issue_log.size(), 2);
        chk("contest2_order", {issue_log[0], issue_log[1]}, 2'b01);
        $display("txn contest2 done");

        for (int i = 0; i < NV; i++) begin
            rm_delay = vecs[i].delay;
            rm_data  = vecs[i].rd_val;
            rm_err   = vecs[i].err;
            req_seen = 1'b0;
            if (vecs[i].is_wr) push_wr(vecs[i].exp_resp);
            else               push_rd(vecs[i].exp_resp, vecs[i].exp_rdata);
            send(vecs[i].is_wr, vecs[i].is_wr, !vecs[i].is_wr,
                 vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].addr);
            wait_idle(60, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_req", i), req_seen, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d_bus_addr", i), {first_wr, first_addr},
                    {vecs[i].is_wr, vecs[i].exp_baddr});
                if (vecs[i].is_wr) begin
                    chk($sformatf("vec%0d_biten", i), first_biten, vecs[i].exp_biten);
                    chk($sformatf("vec%0d_wdata", i), first_data, vecs[i].wdata);
                end
            end
            $display("txn vec%0d wr=%0d addr=%h resp=%0h", i, vecs[i].is_wr, vecs[i].addr, vecs[i].exp_resp);
        end

        // Timeout: bus_req for exactly 16 cycles, then a stray bus_ready.
        rm_delay = -1;
        push_wr(2'b10);
        send(1'b1, 1'b1, 1'b0, 32'h38, 32'hFACE_FACE, 4'hF, 32'h0);
        wait_idle(60, "timeout");
        chk("timeout_req_len", last_req_len, 16);
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        tick();
        chk("stray_ignored", {BVALID, RVALID, bus_req}, 3'b000);
        rm_delay = 1; rm_data = 32'h600D_CAFE; rm_err = 1'b0;
        push_rd(2'b00, 32'h600D_CAFE);
        send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h14);
        wait_idle(60, "after_stray");
        $display("txn timeout addr=38 done");

        // Asynchronous reset in the middle of a bus write.
        rm_delay = -1;
        push_wr(2'b10);
        send(1'b1, 1'b1, 1'b0, 32'h40, 32'h1111_2222, 4'hF, 32'h0);
        tick();
        tick();
        chk("busy_before_rst", {bus_req, bus_req_is_wr}, 2'b11);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_async_req", {bus_req, bus_addr, bus_wr_biten}, '0);
        chk("rst_async_valid", {BVALID, RVALID}, 2'b00);
        chk("rst_async_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        exp_wr_q.delete();
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        chk("rst_discard", BVALID, 1'b0);
        rm_delay = 0; rm_data = 32'h0F0F_0F0F;
        push_rd(2'b00, 32'h0F0F_0F0F);
        send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h18);
        wait_idle(60, "post_reset_read");
        tick();
        tick();
        $display("txn mid_reset done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
